// File: rtl/ps2_scancode_ctrl.sv
// PS/2 Set-2 scan-code sequencer: strips E0/F0/E1 prefixes, tracks modifiers, queues key events.
// Latency: a byte strobed in cycle N appears at the FIFO head in N+1 when the FIFO was empty.
// Backpressure: valid/ready FIFO pop; a push into a full FIFO drops the event and sets overflow (PS2_REPEAT_FILTER_EN suppresses repeats).
module ps2_scancode_ctrl #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_pause,
    output logic [3:0] mods,
    output logic       overflow,
    output logic       proto_err,
    input  logic       clear
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

    typedef struct packed {
        logic       pause;
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ev_t;

    state_t        state, state_nxt;
    logic [2:0]    skip_cnt, skip_nxt;
    logic [TW-1:0] timer;
    logic          emit, perr, push;
    ev_t           em;
    logic [3:0]    mods_nxt;
    logic          is_pfx, is_ign;

    assign is_pfx = (byte_in == 8'hE0) || (byte_in == 8'hF0) || (byte_in == 8'hE1);
    assign is_ign = (byte_in == 8'h00) || (byte_in == 8'hAA) || (byte_in == 8'hEE) ||
                    (byte_in == 8'hFA) || (byte_in == 8'hFE) || (byte_in == 8'hFF);

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        emit      = 1'b0;
        perr      = 1'b0;
        em        = '{pause: 1'b0, brk: 1'b0, ext: 1'b0, code: byte_in};
        if (byte_valid) begin
            case (state)
                S_IDLE: begin
                    if (byte_in == 8'hE0)      state_nxt = S_EXT;
                    else if (byte_in == 8'hF0) state_nxt = S_BRK;
                    else if (byte_in == 8'hE1) begin
                        state_nxt = S_SKIP;
                        skip_nxt  = 3'd7;
                    end
                    else if (!is_ign)          emit = 1'b1;
                end
                S_EXT: begin
                    if (byte_in == 8'hF0) state_nxt = S_EXT_BRK;
                    else begin
                        state_nxt = S_IDLE;
                        if (is_pfx) perr = 1'b1;
                        else begin
                            emit   = 1'b1;
                            em.ext = 1'b1;
                        end
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    state_nxt = S_IDLE;
                    if (is_pfx) perr = 1'b1;
                    else begin
                        emit   = 1'b1;
                        em.brk = 1'b1;
                        em.ext = (state == S_EXT_BRK);
                    end
                end
                S_SKIP: begin
                    skip_nxt = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        state_nxt = S_IDLE;
                        emit      = 1'b1;
                        em.pause  = 1'b1;
                        em.code   = 8'hE1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (state != S_IDLE && timer == TW'(TIMEOUT)) begin
            perr      = 1'b1;
            state_nxt = S_IDLE;
        end
    end

    // Modifiers follow every decoded make/break, whether or not the FIFO has room.
    always_comb begin
        mods_nxt = mods;
        if (emit && !em.pause) begin
            if (em.code == 8'h12 && !em.ext) mods_nxt[0] = !em.brk;
            if (em.code == 8'h59 && !em.ext) mods_nxt[1] = !em.brk;
            if (em.code == 8'h14)            mods_nxt[2] = !em.brk;
            if (em.code == 8'h11)            mods_nxt[3] = !em.brk;
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic       held_vld;
    logic [7:0] held_code;
    logic       held_ext;
    logic       held_match, suppress;

    assign held_match = held_vld && (held_code == em.code) && (held_ext == em.ext);
    assign suppress   = emit && !em.pause && !em.brk && held_match;
    assign push       = emit && !suppress;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_vld  <= 1'b0;
            held_code <= 8'h00;
            held_ext  <= 1'b0;
        end else if (emit && !em.pause) begin
            if (!em.brk) begin
                held_vld  <= 1'b1;
                held_code <= em.code;
                held_ext  <= em.ext;
            end else if (held_match) begin
                held_vld <= 1'b0;
            end
        end
    end
`else
    assign push = emit;
`endif

    // FIFO: extra pointer MSB distinguishes full from empty.
    ev_t           mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, do_pop, do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = ev_valid && ev_ready;
    assign do_push = push && (!full || do_pop);

    assign ev_valid = !empty;
    assign ev_code  = mem[rd_ptr[AW-1:0]].code;
    assign ev_ext   = mem[rd_ptr[AW-1:0]].ext;
    assign ev_break = mem[rd_ptr[AW-1:0]].brk;
    assign ev_pause = mem[rd_ptr[AW-1:0]].pause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            skip_cnt  <= 3'd0;
            timer     <= '0;
            mods      <= 4'h0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
            mods     <= mods_nxt;
            if (byte_valid || state == S_IDLE) timer <= '0;
            else                               timer <= timer + TW'(1);
            if (push && !do_push) overflow <= 1'b1;
            else if (clear)       overflow <= 1'b0;
            if (perr)             proto_err <= 1'b1;
            else if (clear)       proto_err <= 1'b0;
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= em;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: doc/ps2_scancode_ctrl.md
Name: ps2_scancode_ctrl

Overview:
Sequencer downstream of the PS/2 byte decoder. It consumes raw Set-2 scan-code bytes and tracks the E0 (extended), F0 (break) and E1 (pause) prefix sequences. It maintains live modifier state and queues complete key events in a small FIFO, read with a valid/ready handshake. It sits between the byte decoder and the system-side consumer (keymap or CPU register block), in the system clock domain.

Parameters:
DEPTH, 8, event FIFO depth in entries; power of two, 2..64.
TIMEOUT, 65535, max clk cycles allowed between bytes of a multi-byte sequence; must be >= 1.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
byte_in  in  8  scan-code byte from decoder
byte_valid  in  1  one-cycle strobe; byte_in valid this cycle (upstream edge-detects decoder done)
ev_valid  out  1  FIFO head holds an event
ev_ready  in  1  consumer accepts head when ev_valid & ev_ready
ev_code  out  8  head event base scan code (prefixes stripped)
ev_ext  out  1  head event was E0-prefixed
ev_break  out  1  head event is a release
ev_pause  out  1  head event is Pause key; ev_code=8'hE1, ev_ext=0, ev_break=0
mods  out  4  {alt, ctrl, rshift, lshift} currently held
overflow  out  1  sticky: event dropped because FIFO full
proto_err  out  1  sticky: sequence timeout or illegal prefix order
clear  in  1  synchronous; clears overflow and proto_err

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, FIFO empty, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, ev_pause=0, mods=0, overflow=0, proto_err=0, timer=0. Reset mid-sequence discards the partial sequence.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (inside E1 sequence; 7-byte counter).
- IDLE, on byte_valid:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> SKIP, skip count=7.
  - Any of 00/AA/EE/FA/FE/FF: ignored, stay IDLE.
  - Other byte: emit make{code, ext=0, break=0}.
- EXT: F0 -> EXT_BRK; E0 or E1 -> proto_err=1, IDLE; other byte -> emit make{code, ext=1}, IDLE.
- BRK: E0/E1/F0 -> proto_err=1, IDLE; other byte -> emit break{code, ext=0}, IDLE.
- EXT_BRK: E0/E1/F0 -> proto_err=1, IDLE; other byte -> emit break{code, ext=1}, IDLE.
- SKIP: every byte decrements the count; contents are not checked. When the count reaches 0 (7th byte), emit pause event and go to IDLE.
- Timeout: timer clears on every byte_valid and counts while state != IDLE. At timer==TIMEOUT: proto_err=1, state=IDLE, nothing emitted.
- Modifier update, in the same cycle as the emit decision and independent of FIFO space:
  - 12 (ext=0) -> lshift.
  - 59 (ext=0) -> rshift.
  - 14 (either ext) -> ctrl.
  - 11 (either ext) -> alt.
  - make sets the bit, break clears it.
- Latency: byte_valid in cycle N emits the event into the FIFO at the edge ending N. ev_valid and the head fields are valid in N+1 when the FIFO was empty.
- FIFO: registered head outputs, first-word-fall-through.
  - Pop on ev_valid & ev_ready.
  - Push when full is accepted only if a pop occurs in the same cycle. Otherwise the event is dropped and overflow=1.
  - Push and pop on an empty FIFO: the pop is invalid (ev_valid=0) and the push proceeds.
- Head fields are stable while ev_valid & ~ev_ready.
- clear: clears overflow/proto_err next edge. If a set condition occurs the same cycle, set wins.
- Pointer wrap: log2(DEPTH)+1-bit pointers; full/empty derived from the MSB difference.

Optional Feature:
PS2_REPEAT_FILTER_EN:
- Defined: the block stores the last emitted make {code, ext} plus a held flag.
  - A make identical to the held key is suppressed: not pushed, no overflow possible. Modifiers are unaffected.
  - A break of the held key clears the held flag.
  - A different make replaces the held key.
  - Reset clears the held flag.
- Undefined: every typematic repeat make is queued as a separate event.

Test Plan:
- Byte 1C -> one event {code=1C, ext=0, break=0} with ev_valid one cycle after the strobe; then F0,1C -> {1C, break=1}.
- E0,F0,14 after E0,14 -> events {14,ext=1,make} then {14,ext=1,break}; mods[2] 1 then 0; 12 then F0 12 toggles mods[0].
- E1,14,77,E1,F0,14,F0,77 -> exactly one event ev_pause=1 ev_code=E1; mods unchanged; no proto_err.
- ev_ready=0, DEPTH+1 makes -> DEPTH events retained in order, overflow=1. Then drain: FIFO empties, overflow stays 1 until clear; full plus simultaneous push/pop -> no drop.
- E0 then no byte for TIMEOUT cycles -> proto_err=1, FSM idle, no event; a following 1C gives ext=0. Also E0,E0 -> proto_err=1.
- PS2_REPEAT_FILTER_EN: 1C,1C,1C,F0,1C -> events make 1C, break 1C only; without the macro -> 3 makes + 1 break.
